cordic_scheduler: RTL and testbench

Arbitrating front-end for the shared CORDIC kernel. Accepts samples from NUM_REQ independent requesters over valid/ready, grants at most one per cycle round-robin, drives the kernel's input and output-enable, tracks each sample through the fixed-latency pipeline, and returns results tagged with the requester index through a backpressured result FIFO. Credit-based admission guarantees no result is ever lost: the kernel cannot stall.

---
 rtl/cordic_scheduler_pkg.sv | 17 +
 rtl/cordic_result_fifo.sv | 62 ++++++
 rtl/cordic_scheduler.sv | 122 ++++++++++++
 tb/tb_cordic_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_scheduler_pkg.sv
// Shared settings for the CORDIC front-end: data width, kernel delay and the
// per-sample tag carried alongside the kernel pipeline.
package cordic_scheduler_pkg;

  localparam int unsigned SIZE_DATA      = 16;
  localparam int unsigned SIZE_SHIFT_REG = 4;
  localparam int unsigned KERNEL_LATENCY = SIZE_SHIFT_REG + 1;

  // Wide enough for the largest supported requester count (16).
  localparam int unsigned TAG_ID_W = 4;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } cordic_tag_t;

endpackage

// File: rtl/cordic_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count; read data is
// forced to zero while empty so the result port idles at zero.
module cordic_result_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop;
  logic             full;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = rd_i & ~empty_o;
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_i && !pop)      count_d = count_q + CW'(1);
    else if (!wr_i && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Admission credits must make an unpopped write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(wr_i && full && !rd_i));

endmodule

// File: rtl/cordic_scheduler.sv
// Round-robin, credit-admitted front-end for the shared fixed-latency CORDIC
// kernel; returns results in grant order, tagged with the requester index.
module cordic_scheduler
  import cordic_scheduler_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned FIFO_DEPTH = 8,
  localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ-1:0][SIZE_DATA-1:0] req_data_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [SIZE_DATA-1:0]              kern_input_data_o,
  output logic                              kern_enable_o,
  input  logic signed [SIZE_DATA-1:0]       kern_output_data_i,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic signed [SIZE_DATA-1:0]       res_data_o,
  output logic [ID_W-1:0]                   res_id_o,
  output logic                              busy_o
);

  localparam int unsigned L     = SIZE_SHIFT_REG;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned INF_W = $clog2(KERNEL_LATENCY + 1);
  localparam int unsigned FW    = SIZE_DATA + ID_W;

  cordic_tag_t      tag_q [KERNEL_LATENCY];
  cordic_tag_t      tag_d [KERNEL_LATENCY];
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [INF_W-1:0] inflight_q, inflight_d;

  logic             grant_c;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  cand;
  logic             credit_ok;
  logic             fifo_wr;
  logic             fifo_rd;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [FW-1:0]    fifo_wdata;
  logic [FW-1:0]    fifo_rdata;

  // Registered counts only: a pop this cycle frees its credit next cycle.
  assign credit_ok = (32'(inflight_q) + 32'(fifo_count)) < 32'(FIFO_DEPTH);

  // Round-robin search starting at rr_ptr; blocked during reset.
  always_comb begin
    grant_c           = 1'b0;
    grant_id          = '0;
    cand              = '0;
    req_ready_o       = '0;
    kern_input_data_o = '0;
    if (!reset && credit_ok) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
        if (!grant_c && req_valid_i[cand]) begin
          grant_c  = 1'b1;
          grant_id = cand;
        end
      end
      if (grant_c) begin
        req_ready_o[grant_id] = 1'b1;
        kern_input_data_o     = req_data_i[grant_id];
      end
    end
  end

  assign fifo_wr       = tag_q[L].valid;
  assign fifo_wdata    = {kern_output_data_i, tag_q[L].id[ID_W-1:0]};
  assign kern_enable_o = tag_q[L-1].valid;

  always_comb begin
    tag_d[0].valid = grant_c;
    tag_d[0].id    = TAG_ID_W'(grant_id);
    for (int unsigned s = 1; s < KERNEL_LATENCY; s++) tag_d[s] = tag_q[s-1];

    rr_ptr_d = rr_ptr_q;
    if (grant_c)
      rr_ptr_d = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);

    inflight_d = inflight_q;
    if (grant_c && !fifo_wr)      inflight_d = inflight_q + INF_W'(1);
    else if (!grant_c && fifo_wr) inflight_d = inflight_q - INF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < KERNEL_LATENCY; s++) tag_q[s] <= '0;
      rr_ptr_q   <= '0;
      inflight_q <= '0;
    end else begin
      tag_q      <= tag_d;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  assign fifo_rd = res_ready_i;

  cordic_result_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (fifo_wr),
    .wdata_i (fifo_wdata),
    .rd_i    (fifo_rd),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign res_valid_o = ~fifo_empty;
  assign res_data_o  = fifo_rdata[FW-1 -: SIZE_DATA];
  assign res_id_o    = fifo_rdata[ID_W-1:0];
  assign busy_o      = (inflight_q != '0) || !fifo_empty;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Scoreboard bench: a transaction-level model predicts grants, kernel enables
// and result arrival times; a monitor pops expected results as they appear.
module tb_cordic_scheduler;
  import cordic_scheduler_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned L     = SIZE_SHIFT_REG;
  localparam int unsigned DW    = SIZE_DATA;

  logic                 clk;
  logic                 reset;
  logic [N-1:0]         req_valid;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0]         req_ready;
  logic [DW-1:0]        kern_input_data;
  logic                 kern_enable;
  logic [DW-1:0]        kern_output_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [DW-1:0]        res_data;
  logic [1:0]           res_id;
  logic                 busy;

  cordic_scheduler #(.NUM_REQ(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid_i        (req_valid),
    .req_data_i         (req_data),
    .req_ready_o        (req_ready),
    .kern_input_data_o  (kern_input_data),
    .kern_enable_o      (kern_enable),
    .kern_output_data_i (kern_output_data),
    .res_valid_o        (res_valid),
    .res_ready_i        (res_ready),
    .res_data_o         (res_data),
    .res_id_o           (res_id),
    .busy_o             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in kernel: L-deep delay line, output register loaded on enable, identity transform.
  logic [DW-1:0] ksr [L];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(L); i++) ksr[i] <= '0;
      kern_output_data <= '0;
    end else begin
      ksr[0] <= kern_input_data;
      for (int i = 1; i < int'(L); i++) ksr[i] <= ksr[i-1];
      if (kern_enable) kern_output_data <= ksr[L-1];
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    int            id;
    int            cyc;
  } exp_t;

  exp_t   exp_q[$];
  bit     en_hist[int];
  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;
  int     grants = 0;
  int     mon_pops = 0;
  int     pop_base = 0;
  int     mon_last_pop = -1;
  int     rr = 0;
  int     hs_count = 0;
  logic [N-1:0] hs_last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: result port against the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      automatic bit exp_v = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
      chk("res_valid", {31'b0, res_valid}, {31'b0, exp_v});
      if (exp_v && res_valid) begin
        chk("res_data", {16'b0, res_data}, {16'b0, exp_q[0].data});
        chk("res_id", {30'b0, res_id}, 32'(exp_q[0].id));
      end
      if (exp_v && res_ready) begin
        void'(exp_q.pop_front());
        mon_pops++;
        mon_last_pop = cyc;
      end
    end
  end

  // Reference model: credit = grants so far minus pops in earlier cycles.
  always @(negedge clk) begin
    #1;
    hs_last = req_valid & req_ready;
    if (hs_last != '0) hs_count++;
    if (reset) begin
      exp_q.delete();
      en_hist.delete();
      grants   = 0;
      pop_base = mon_pops;
      rr       = 0;
    end else begin
      automatic int used = grants - (mon_pops - pop_base - ((mon_last_pop == cyc) ? 1 : 0));
      automatic int g = -1;
      if (used < int'(DEPTH)) begin
        for (int k = 0; k < int'(N); k++)
          if (g < 0 && req_valid[2'((rr + k) % int'(N))]) g = (rr + k) % int'(N);
      end
      chk("req_ready", {28'b0, req_ready}, (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("kern_input_data", {16'b0, kern_input_data},
          (g >= 0) ? {16'b0, req_data[2'(g)]} : 32'd0);
      chk("kern_enable", {31'b0, kern_enable}, {31'b0, en_hist.exists(cyc - int'(L))});
      chk("busy", {31'b0, busy}, {31'b0, (used > 0)});
      if (g >= 0) begin
        exp_q.push_back('{data: req_data[2'(g)], id: g, cyc: cyc + int'(L) + 2});
        en_hist[cyc] = 1'b1;
        grants++;
        rr = (g + 1) % int'(N);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Randomised requesters that hold valid/data until handshaken.
  task automatic run(input int n, input int unsigned pv, input int unsigned pr);
    for (int c = 0; c < n; c++) begin
      nxt();
      for (int i = 0; i < int'(N); i++) begin
        if (!req_valid[i] || hs_last[i]) begin
          req_valid[i] = ($urandom_range(99) < pv);
          req_data[i]  = DW'($urandom);
        end
      end
      res_ready = ($urandom_range(99) < pr);
    end
  endtask

  initial begin
    int h;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single request from requester 2.
    nxt(); req_valid = 4'b0100; req_data[2] = 16'h1234;
    @(negedge clk); chk("single_grant", {28'b0, req_ready}, 32'h4);
    nxt(); req_valid = '0;
    run(10, 0, 100);

    // All requesters streaming, consumer always ready.
    run(12, 100, 100);
    run(12, 0, 100);

    // Consumer stalled: credits run out after DEPTH grants.
    h = hs_count;
    run(20, 100, 0);
    chk("credit_stop", 32'(hs_count - h), 32'(DEPTH));
    h = hs_count;
    run(1, 100, 100);
    run(5, 100, 0);
    chk("pulse_grant", 32'(hs_count - h), 32'd1);

    // Full FIFO with consumer ready: simultaneous write and pop.
    run(40, 100, 100);
    run(20, 0, 100);

    // Reset with samples in flight and in the FIFO.
    for (int c = 0; c < 5; c++) begin
      nxt(); req_valid = '1; res_ready = 1'b0;
      for (int i = 0; i < int'(N); i++) req_data[i] = DW'($urandom);
    end
    nxt(); req_valid = '0;
    nxt();
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
    chk("rst_kern_data", {16'b0, kern_input_data}, 32'd0);
    chk("rst_kern_enable", {31'b0, kern_enable}, 32'd0);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_res_data", {16'b0, res_data}, 32'd0);
    chk("rst_res_id", {30'b0, res_id}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    nxt(); req_valid = '1; res_ready = 1'b1;
    @(negedge clk); chk("post_reset_grant", {28'b0, req_ready}, 32'h1);
    nxt(); req_valid = '0;
    run(15, 0, 100);

    // Round-robin wrap: requester 3 then requester 1 from rr_ptr = 0.
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0;
    nxt(); req_valid = 4'b1000; req_data[3] = DW'($urandom);
    @(negedge clk); chk("wrap_first", {28'b0, req_ready}, 32'h8);
    nxt(); req_valid = 4'b0010; req_data[1] = DW'($urandom);
    @(negedge clk); chk("wrap_second", {28'b0, req_ready}, 32'h2);
    nxt(); req_valid = '0;
    run(10, 0, 100);

    // Random traffic with a reset in the middle.
    run(300, 50, 70);
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0;
    run(300, 60, 60);
    run(30, 0, 100);
    @(negedge clk);
    chk("final_idle", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
